// File: rtl/ysyx_23060187_alu_arb_if.sv
// Client-side handshake bundle for the shared-ALU arbiter: two request ports
// and their one-entry response buffers.
interface ysyx_23060187_alu_arb_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_ctrl;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_ctrl;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [31:0] rsp0_result;
    logic [2:0]  rsp0_flags;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp1_result;
    logic [2:0]  rsp1_flags;

    modport master (
        output req0_valid, req0_ctrl, req0_a, req0_b,
        output req1_valid, req1_ctrl, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_flags,
        input  rsp1_valid, rsp1_result, rsp1_flags
    );

    modport slave (
        input  req0_valid, req0_ctrl, req0_a, req0_b,
        input  req1_valid, req1_ctrl, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp0_flags,
        output rsp1_valid, rsp1_result, rsp1_flags
    );
endinterface

// File: rtl/ysyx_23060187_alu_arb.sv
// Round-robin arbiter time-sharing one combinational ALU between two clients,
// with a registered one-entry response buffer per client.
module ysyx_23060187_alu_arb (
    input  logic                          clk,
    input  logic                          rst_n,
    ysyx_23060187_alu_arb_if.slave        cli,
    output logic [3:0]                    alu_ctrl,
    output logic [31:0]                   alu_opnum1,
    output logic [31:0]                   alu_opnum2,
    input  logic [31:0]                   alu_result,
    input  logic                          alu_zero,
    input  logic                          alu_cout,
    input  logic                          alu_overflow
);
    typedef enum logic {PRIO_0 = 1'b0, PRIO_1 = 1'b1} prio_t;

    prio_t       prio_q, prio_d;
    logic        elig0, elig1, gnt0, gnt1;
    logic        rsp0_valid_q, rsp1_valid_q;
    logic [31:0] rsp0_result_q, rsp1_result_q;
    logic [2:0]  rsp0_flags_q, rsp1_flags_q;

    always_comb begin
        // A full buffer being drained this cycle counts as free.
        elig0 = cli.req0_valid && (!rsp0_valid_q || cli.rsp0_ready);
        elig1 = cli.req1_valid && (!rsp1_valid_q || cli.rsp1_ready);
        gnt0  = elig0 && (!elig1 || (prio_q == PRIO_0));
        gnt1  = elig1 && (!elig0 || (prio_q == PRIO_1));

        prio_d = prio_q;
        if (gnt0)
            prio_d = PRIO_1;
        else if (gnt1)
            prio_d = PRIO_0;

        alu_ctrl   = '0;
        alu_opnum1 = '0;
        alu_opnum2 = '0;
        if (gnt0) begin
            alu_ctrl   = cli.req0_ctrl;
            alu_opnum1 = cli.req0_a;
            alu_opnum2 = cli.req0_b;
        end else if (gnt1) begin
            alu_ctrl   = cli.req1_ctrl;
            alu_opnum1 = cli.req1_a;
            alu_opnum2 = cli.req1_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prio_q <= PRIO_0;
        else
            prio_q <= prio_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp0_flags_q  <= '0;
        end else if (gnt0) begin
            rsp0_valid_q  <= 1'b1;
            rsp0_result_q <= alu_result;
            rsp0_flags_q  <= {alu_overflow, alu_cout, alu_zero};
        end else if (rsp0_valid_q && cli.rsp0_ready) begin
            rsp0_valid_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp1_valid_q  <= 1'b0;
            rsp1_result_q <= '0;
            rsp1_flags_q  <= '0;
        end else if (gnt1) begin
            rsp1_valid_q  <= 1'b1;
            rsp1_result_q <= alu_result;
            rsp1_flags_q  <= {alu_overflow, alu_cout, alu_zero};
        end else if (rsp1_valid_q && cli.rsp1_ready) begin
            rsp1_valid_q  <= 1'b0;
        end
    end

    assign cli.req0_ready  = gnt0;
    assign cli.req1_ready  = gnt1;
    assign cli.rsp0_valid  = rsp0_valid_q;
    assign cli.rsp0_result = rsp0_result_q;
    assign cli.rsp0_flags  = rsp0_flags_q;
    assign cli.rsp1_valid  = rsp1_valid_q;
    assign cli.rsp1_result = rsp1_result_q;
    assign cli.rsp1_flags  = rsp1_flags_q;
endmodule

// File: tb/tb_ysyx_23060187_alu_arb.sv
// Directed bench for the ALU arbiter: a per-cycle vector table plus hand
// sequences for idle, reset-while-pending and post-reset priority.
module tb_ysyx_23060187_alu_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_opnum1, alu_opnum2, alu_result;
    logic        alu_zero, alu_cout, alu_overflow;
    logic [32:0] sum, dif;

    int n_chk = 0;
    int n_fail = 0;

    ysyx_23060187_alu_arb_if bus();

    ysyx_23060187_alu_arb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cli          (bus.slave),
        .alu_ctrl     (alu_ctrl),
        .alu_opnum1   (alu_opnum1),
        .alu_opnum2   (alu_opnum2),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_cout     (alu_cout),
        .alu_overflow (alu_overflow)
    );

    always #5 clk = ~clk;

    // Stand-in for the core's ALU; SUB overflow is the unsigned borrow a < b.
    always_comb begin
        sum = {1'b0, alu_opnum1} + {1'b0, alu_opnum2};
        dif = {1'b0, alu_opnum1} + {1'b0, ~alu_opnum2} + 33'd1;
        alu_result = '0;
        alu_cout = 1'b0;
        alu_overflow = 1'b0;
        case (alu_ctrl)
            4'd0: alu_result = alu_opnum1 & alu_opnum2;
            4'd1: alu_result = alu_opnum1 | alu_opnum2;
            4'd2: begin
                alu_result = sum[31:0];
                alu_cout = sum[32];
                alu_overflow = (alu_opnum1[31] == alu_opnum2[31]) && (sum[31] != alu_opnum1[31]);
            end
            4'd3: alu_result = alu_opnum1 << alu_opnum2[4:0];
            4'd4: alu_result = alu_opnum1 >> alu_opnum2[4:0];
            4'd5: alu_result = alu_opnum1 ^ alu_opnum2;
            4'd6: begin
                alu_result = dif[31:0];
                alu_cout = dif[32];
                alu_overflow = alu_opnum1 < alu_opnum2;
            end
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    typedef struct {
        logic v0; logic [3:0] c0; logic [31:0] a0, b0;
        logic v1; logic [3:0] c1; logic [31:0] a1, b1;
        logic rr0, rr1;
        logic rdy0, rdy1;
        logic [3:0] actl; logic [31:0] aop1, aop2;
        logic sv0; logic [31:0] sr0; logic [2:0] sf0;
        logic sv1; logic [31:0] sr1; logic [2:0] sf1;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                         input logic rr0, input logic rr1);
        bus.req0_valid = v0; bus.req0_ctrl = c0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = v1; bus.req1_ctrl = c1; bus.req1_a = a1; bus.req1_b = b1;
        bus.rsp0_ready = rr0; bus.rsp1_ready = rr1;
    endtask

    initial begin
        // Each row is one cycle; the rsp fields are the buffer state seen in that cycle.
        tbl[0]  = '{1,2,32'h7FFFFFFF,1, 0,0,0,0, 1,1, 1,0, 2,32'h7FFFFFFF,1, 0,0,0, 0,0,0};
        tbl[1]  = '{0,0,0,0, 1,3,1,4, 0,1, 0,1, 3,1,4, 1,32'h80000000,3'b100, 0,0,0};
        tbl[2]  = '{0,0,0,0, 1,5,32'hFF00FF00,32'hFFFFFFFF, 0,1, 0,1, 5,32'hFF00FF00,32'hFFFFFFFF,
                    1,32'h80000000,3'b100, 1,32'h10,3'b000};
        tbl[3]  = '{0,0,0,0, 1,9,32'h12345678,32'h9ABCDEF0, 1,1, 0,1, 9,32'h12345678,32'h9ABCDEF0,
                    1,32'h80000000,3'b100, 1,32'h00FF00FF,3'b000};
        tbl[4]  = '{1,0,32'hF0F0F0F0,32'hFF00FF00, 1,1,32'h0F0F0000,32'hFF, 1,1, 1,0, 0,32'hF0F0F0F0,32'hFF00FF00,
                    0,32'h80000000,3'b100, 1,0,3'b001};
        tbl[5]  = '{1,2,32'hFFFFFFFF,1, 1,1,32'h0F0F0000,32'hFF, 1,1, 0,1, 1,32'h0F0F0000,32'hFF,
                    1,32'hF000F000,3'b000, 0,0,3'b001};
        tbl[6]  = '{1,2,32'hFFFFFFFF,1, 1,4,32'h80000000,31, 1,1, 1,0, 2,32'hFFFFFFFF,1,
                    0,32'hF000F000,3'b000, 1,32'h0F0F00FF,3'b000};
        tbl[7]  = '{1,6,3,5, 1,4,32'h80000000,31, 1,1, 0,1, 4,32'h80000000,31,
                    1,0,3'b011, 0,32'h0F0F00FF,3'b000};
        tbl[8]  = '{1,6,3,5, 0,0,0,0, 1,1, 1,0, 6,3,5, 0,0,3'b011, 1,1,3'b000};
        tbl[9]  = '{0,0,0,0, 0,0,0,0, 1,0, 0,0, 0,0,0, 1,32'hFFFFFFFE,3'b100, 0,1,3'b000};
        tbl[10] = '{1,6,5,5, 0,0,0,0, 0,1, 1,0, 6,5,5, 0,32'hFFFFFFFE,3'b100, 0,1,3'b000};
        tbl[11] = '{1,0,32'hFFFFFFFF,32'hFFFF, 1,2,1,2, 0,1, 0,1, 2,1,2, 1,0,3'b011, 0,1,3'b000};
        tbl[12] = '{1,0,32'hFFFFFFFF,32'hFFFF, 1,2,32'h10,32'h20, 0,1, 0,1, 2,32'h10,32'h20,
                    1,0,3'b011, 1,3,3'b000};
        tbl[13] = '{1,0,32'hFFFFFFFF,32'hFFFF, 1,2,32'h30,1, 1,1, 1,0, 0,32'hFFFFFFFF,32'hFFFF,
                    1,0,3'b011, 1,32'h30,3'b000};
        tbl[14] = '{0,0,0,0, 1,2,32'h30,1, 1,1, 0,1, 2,32'h30,1, 1,32'hFFFF,3'b000, 0,32'h30,3'b000};
        tbl[15] = '{0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0,0, 0,32'hFFFF,3'b000, 1,32'h31,3'b000};

        drive(0,0,0,0, 0,0,0,0, 0,0);
        #12;
        chk("reset rsp0_valid", 32'(bus.rsp0_valid), 0);
        chk("reset rsp1_valid", 32'(bus.rsp1_valid), 0);
        chk("reset rsp0_result", bus.rsp0_result, 0);
        chk("reset rsp1_flags", 32'(bus.rsp1_flags), 0);
        chk("reset alu_ctrl", 32'(alu_ctrl), 0);
        chk("reset alu_opnum1", alu_opnum1, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            drive(tbl[i].v0, tbl[i].c0, tbl[i].a0, tbl[i].b0, tbl[i].v1, tbl[i].c1, tbl[i].a1, tbl[i].b1,
                  tbl[i].rr0, tbl[i].rr1);
            #1;
            chk($sformatf("v%0d req0_ready", i), 32'(bus.req0_ready), 32'(tbl[i].rdy0));
            chk($sformatf("v%0d req1_ready", i), 32'(bus.req1_ready), 32'(tbl[i].rdy1));
            chk($sformatf("v%0d alu_ctrl", i), 32'(alu_ctrl), 32'(tbl[i].actl));
            chk($sformatf("v%0d alu_opnum1", i), alu_opnum1, tbl[i].aop1);
            chk($sformatf("v%0d alu_opnum2", i), alu_opnum2, tbl[i].aop2);
            chk($sformatf("v%0d rsp0_valid", i), 32'(bus.rsp0_valid), 32'(tbl[i].sv0));
            chk($sformatf("v%0d rsp0_result", i), bus.rsp0_result, tbl[i].sr0);
            chk($sformatf("v%0d rsp0_flags", i), 32'(bus.rsp0_flags), 32'(tbl[i].sf0));
            chk($sformatf("v%0d rsp1_valid", i), 32'(bus.rsp1_valid), 32'(tbl[i].sv1));
            chk($sformatf("v%0d rsp1_result", i), bus.rsp1_result, tbl[i].sr1);
            chk($sformatf("v%0d rsp1_flags", i), 32'(bus.rsp1_flags), 32'(tbl[i].sf1));
        end

        // Idle: ALU drive stays zero and both buffers hold.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            drive(0,0,0,0, 0,0,0,0, 0,0);
            #1;
            chk($sformatf("idle%0d alu_ctrl", i), 32'(alu_ctrl), 0);
            chk($sformatf("idle%0d alu_ops", i), alu_opnum1 | alu_opnum2, 0);
            chk($sformatf("idle%0d readies", i), 32'({bus.req0_ready, bus.req1_ready}), 0);
            chk($sformatf("idle%0d rsp1_valid", i), 32'(bus.rsp1_valid), 1);
            chk($sformatf("idle%0d rsp1_result", i), bus.rsp1_result, 32'h31);
            chk($sformatf("idle%0d rsp0_valid", i), 32'(bus.rsp0_valid), 0);
        end

        // Priority held across idle: port 0 still wins contention.
        @(posedge clk); #1;
        drive(1,0,1,1, 1,1,2,0, 1,1);
        #1;
        chk("post-idle req0_ready", 32'(bus.req0_ready), 1);
        chk("post-idle req1_ready", 32'(bus.req1_ready), 0);
        @(posedge clk); #1;
        drive(0,0,0,0, 1,1,2,0, 1,1);
        #1;
        chk("seq req1_ready", 32'(bus.req1_ready), 1);
        chk("seq rsp0_result", bus.rsp0_result, 1);
        @(posedge clk); #1;
        drive(1,0,3,3, 0,0,0,0, 1,0);
        #1;
        chk("seq2 req0_ready", 32'(bus.req0_ready), 1);
        chk("seq2 rsp1_result", bus.rsp1_result, 2);

        // Reset between edges with both buffers full; prio is 1 at this point.
        @(posedge clk); #1;
        drive(0,0,0,0, 0,0,0,0, 0,0);
        #1;
        chk("pre-reset rsp1_valid", 32'(bus.rsp1_valid), 1);
        chk("pre-reset rsp0_valid", 32'(bus.rsp0_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-reset rsp1_valid", 32'(bus.rsp1_valid), 0);
        chk("mid-reset rsp0_valid", 32'(bus.rsp0_valid), 0);
        chk("mid-reset rsp1_result", bus.rsp1_result, 0);
        chk("mid-reset rsp0_result", bus.rsp0_result, 0);
        @(posedge clk); #3 rst_n = 1'b1;

        @(posedge clk); #1;
        drive(1,2,2,3, 1,1,4,4, 1,1);
        #1;
        chk("after-reset req0_ready", 32'(bus.req0_ready), 1);
        chk("after-reset req1_ready", 32'(bus.req1_ready), 0);
        chk("after-reset rsp1_valid", 32'(bus.rsp1_valid), 0);
        @(posedge clk); #1;
        drive(0,0,0,0, 1,1,4,4, 1,1);
        #1;
        chk("after-reset rsp0_valid", 32'(bus.rsp0_valid), 1);
        chk("after-reset rsp0_result", bus.rsp0_result, 5);
        chk("after-reset rsp1_valid2", 32'(bus.rsp1_valid), 0);
        chk("after-reset req1_ready2", 32'(bus.req1_ready), 1);
        @(posedge clk); #1;
        drive(0,0,0,0, 0,0,0,0, 1,1);
        #1;
        chk("after-reset rsp1_result", bus.rsp1_result, 4);
        chk("after-reset rsp1_valid3", 32'(bus.rsp1_valid), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_23060187_alu_arb.md
# ysyx_23060187_alu_arb

Two-requester arbiter that time-shares the single combinational ALU of the ysyx_23060187 core. It sits between the ALU and two clients, port 0 (EXU) and port 1 (IFU/LSU address adder). It grants at most one request per cycle with round-robin priority, drives the ALU operands, and registers the ALU outputs into a one-entry response buffer per client. All client interfaces use valid/ready handshakes.

## Interface
- No parameters; data width fixed at 32, op width fixed at 4.
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid, req1_valid  in  1  client i presents an operation
- req0_ready, req1_ready  out  1  client i's operation accepted this cycle (combinational grant)
- req0_ctrl, req1_ctrl  in  4  ALU op: 0 AND, 1 OR, 2 ADD, 3 SLL, 4 SRL, 5 XOR, 6 SUB, 7–15 undefined (ALU returns 0)
- req0_a, req0_b, req1_a, req1_b  in  32  operands
- rsp0_valid, rsp1_valid  out  1  response buffer i holds a result
- rsp0_ready, rsp1_ready  in  1  client i consumes its response
- rsp0_result, rsp1_result  out  32  registered ALU result
- rsp0_flags, rsp1_flags  out  3  registered {overflow, cout, zero}
- alu_ctrl  out  4  to ALU ALUctrl
- alu_opnum1, alu_opnum2  out  32  to ALU operands
- alu_result  in  32  from ALU
- alu_zero, alu_cout, alu_overflow  in  1  from ALU flags

## Operation
- Eligibility: elig[i] = req_valid[i] && (!rsp_valid[i] || rsp_ready[i]). A full buffer being drained in the same cycle counts as free.
- Arbitration: 1-bit pointer `prio`.
  - Only one eligible: that one wins.
  - Both eligible: requester `prio` wins.
  - After any grant to i, prio <= ~i.
  - No grant: prio unchanged.
- req_ready[i] = 1 only for the winner; at most one ready per cycle.
- ALU drive:
  - Grant: alu_ctrl/opnum1/opnum2 = winner's ctrl/a/b, same cycle.
  - No grant: all zero.
- Response buffer i, per cycle:
  - Grant to i: rsp_valid[i] <= 1; result/flags <= ALU outputs. This overwrites only when the old entry is consumed the same cycle, which eligibility guarantees.
  - Else if rsp_valid[i] && rsp_ready[i]: rsp_valid[i] <= 0; data held.
  - Else: hold.
- Flags are captured exactly as the ALU returns them; no reinterpretation. SUB overflow is the ALU's unsigned-borrow definition.
- Client rule: once valid is raised, ctrl/a/b stay stable until ready. The block does not latch requests.
- Undefined ctrl (7–15) is passed through; the response is whatever the ALU returns (result 0, zero 1).

## Timing
- Reset (rst_n low, immediate): rsp0_valid = rsp1_valid = 0; results and flags = 0; prio = 0; alu_* outputs = 0 while no request is valid.
- Reset asserted mid-operation: any buffered response is discarded; no response for that request ever appears.
- Latency: grant in cycle N, rsp_valid high in cycle N+1.
- Throughput:
  - One operation per cycle aggregate.
  - Per client, one per cycle while rsp_ready is held high (back-to-back).
  - rsp_ready low stalls only that client; the other client proceeds.
- Simultaneous requests: alternate 0,1,0,1… while both are continuously eligible.
- No combinational path from rsp_ready[i] to rsp_valid[i]. A combinational path rsp_ready → req_ready exists by design.

## Test plan
- Single ADD: req0 ctrl=2, a=0x7FFFFFFF, b=1 → req0_ready same cycle; next cycle rsp0_valid=1, result=0x80000000, flags={1,0,0}.
- Contention: both valid continuously for 4 cycles, rsp_ready=1 → grants 0,1,0,1; each client gets 2 responses one cycle after its grant.
- Backpressure: req0 SUB a=5, b=5 with rsp0_ready=0 → result 0, zero=1, held. A second req0 stays unready while req1 is granted every cycle. Raising rsp0_ready grants req0 the same cycle.
- Shift/logic: req1 ctrl=3, a=1, b=4 → 0x10; then ctrl=5, a=0xFF00FF00, b=0xFFFFFFFF → 0x00FF00FF; then ctrl=9 → result 0, zero=1.
- Reset mid-operation: rsp1_valid=1 pending, pull rst_n low between edges → rsp1_valid=0 immediately. After release, the first contention grants port 0.
- Idle: no valid for 10 cycles → alu_* outputs = 0, rsp_valid unchanged, prio unchanged.
